// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, frame width and MMIO decode addresses.
// No ports; imported by the controller top.
package uart_pkg;
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
  localparam int FRAME_BITS = 8;
  localparam logic [31:0] MMIO_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] MMIO_STAT_ADDR = 32'h1000_0004;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through sync FIFO for received bytes.
// Ports: clk/rst, push+din write side, pop read side, dout = head (0 when empty),
// full/empty/count status.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_pop, w_push;
  // pop on empty is ignored, so a same-cycle push into an empty FIFO keeps its byte;
  // a push while full only succeeds when a pop frees the head in the same cycle
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign full   = r_count == (AW+1)'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign dout   = empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: 8N1 UART beside the data-path MMIO decode (TX serializer, RX deserializer, RX FIFO).
// Ports: tx_data/tx_we in, tx_busy out; rx_re pop in, rx_data/rx_valid out;
// sticky rx_overrun/rx_frame_err cleared by err_clr; uart_rxd/uart_txd serial pins.
module uart_mmio_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  input  logic       rx_re,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       err_clr,
  input  logic       uart_rxd,
  output logic       uart_txd
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);
  logic [1:0] r_tx_state, w_tx_next;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;
  logic w_tx_tick;
  assign w_tx_tick = r_tx_cnt == DIV_END;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_tx_state <= TX_IDLE;
    else r_tx_state <= w_tx_next;
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (tx_we) w_tx_next = TX_START;
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == LAST_BIT) w_tx_next = TX_STOP;
      default:  if (w_tx_tick) w_tx_next = TX_IDLE;
    endcase
  end
  always_comb begin
    uart_txd = r_tx_state == TX_START ? 1'b0 : r_tx_state == TX_DATA ? r_tx_shift[0] : 1'b1;
    tx_busy  = r_tx_state != TX_IDLE;
  end
  // bit index wraps 7->0 on the last data bit, so it is ready for the next frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_cnt <= (r_tx_state == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
      if (r_tx_state == TX_IDLE && tx_we) r_tx_shift <= tx_data;
      if (r_tx_state == TX_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + 1'b1;
      end
    end
  logic r_rxd_s1, r_rxd_s2, r_rxd_d;
  logic [1:0] r_rx_state, w_rx_next;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic w_rx_fall, w_rx_tick, w_rx_push, w_rx_ferr;
  logic w_fifo_full, w_fifo_empty, w_fifo_pop;
  logic [$clog2(RX_DEPTH):0] w_fifo_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
    end
  assign w_rx_fall = r_rxd_d & ~r_rxd_s2;
  // start bit is checked at half a bit so every later sample lands mid-bit
  assign w_rx_tick = r_rx_state == RX_START ? r_rx_cnt == HALF_END : r_rx_cnt == DIV_END;
  assign w_rx_push = r_rx_state == RX_STOP && w_rx_tick && r_rxd_s2;
  assign w_rx_ferr = r_rx_state == RX_STOP && w_rx_tick && !r_rxd_s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rx_state <= RX_IDLE;
    else r_rx_state <= w_rx_next;
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == LAST_BIT) w_rx_next = RX_STOP;
      default:  if (w_rx_tick) w_rx_next = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_cnt <= (r_rx_state == RX_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
      if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
    end
  assign w_fifo_pop = rx_re & ~w_fifo_empty;
  uart_rx_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .din   (r_rx_shift),
    .pop   (w_fifo_pop),
    .dout  (rx_data),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );
  assign rx_valid = w_fifo_count != '0;
  // a set in the same cycle as err_clr wins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= (w_rx_push && w_fifo_full && !w_fifo_pop) ? 1'b1 : err_clr ? 1'b0 : rx_overrun;
      rx_frame_err <= w_rx_ferr ? 1'b1 : err_clr ? 1'b0 : rx_frame_err;
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: table-driven, scoreboarded bench for uart_mmio_ctrl (DIV=16, depth 4).
module tb_uart_mmio_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_we = 1'b0, rx_re = 1'b0, err_clr = 1'b0, uart_rxd = 1'b1;
  logic tx_busy, rx_valid, rx_overrun, rx_frame_err, uart_txd;
  logic [7:0] rx_data;
  int n_vec = 0, n_err = 0;
  logic [7:0] q[$];
  typedef struct {
    logic [7:0] d;
    logic stop, valid, ovr, ferr;
    int pops;
    logic clr;
  } rx_vec_t;
  typedef struct {
    logic [7:0] d;
    logic inj;
  } tx_vec_t;
  rx_vec_t rv[8];
  tx_vec_t tv[3];
  uart_mmio_ctrl #(.CLK_FREQ(1600), .BAUD(100), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .rx_re(rx_re), .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .err_clr(err_clr), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tx_chk(input logic [7:0] d, input logic inj);
    logic exp_bit;
    tx_data = d;
    tx_we = 1'b1;
    tick(1);
    tx_we = 1'b0;
    for (int i = 0; i < 160; i++) begin
      exp_bit = i < 16 ? 1'b0 : i < 144 ? d[(i-16)/16] : 1'b1;
      chk("uart_txd", {7'b0, uart_txd}, {7'b0, exp_bit});
      chk("tx_busy", {7'b0, tx_busy}, 8'h01);
      if (inj && i == 50) begin
        tx_data = 8'h3C;
        tx_we = 1'b1;
      end else tx_we = 1'b0;
      tick(1);
    end
    chk("tx_busy_end", {7'b0, tx_busy}, 8'h00);
    chk("uart_txd_idle", {7'b0, uart_txd}, 8'h01);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      tick(16);
    end
    uart_rxd = stop;
    tick(16);
    uart_rxd = 1'b1;
    tick(2);
  endtask
  task automatic pop_chk();
    logic [7:0] exp;
    if (q.size() == 0) begin
      chk("rx_valid_pop", {7'b0, rx_valid}, 8'h00);
      return;
    end
    exp = q.pop_front();
    chk("rx_valid_pop", {7'b0, rx_valid}, 8'h01);
    chk("rx_data_pop", rx_data, exp);
    rx_re = 1'b1;
    tick(1);
    rx_re = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0] = '{8'hA5, 1'b1};
    tv[1] = '{8'h00, 1'b0};
    tv[2] = '{8'hFF, 1'b0};
    rv[0] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    rv[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    rv[2] = '{8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    rv[3] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    rv[4] = '{8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    rv[5] = '{8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b1};
    rv[6] = '{8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    rv[7] = '{8'h78, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_txd", {7'b0, uart_txd}, 8'h01);
    chk("rst_busy", {7'b0, tx_busy}, 8'h00);
    chk("rst_valid", {7'b0, rx_valid}, 8'h00);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ovr", {7'b0, rx_overrun}, 8'h00);
    chk("rst_ferr", {7'b0, rx_frame_err}, 8'h00);
    for (int k = 0; k < 3; k++) tx_chk(tv[k].d, tv[k].inj);
    for (int k = 0; k < 8; k++) begin
      send_frame(rv[k].d, rv[k].stop);
      if (rv[k].stop && q.size() < 4) q.push_back(rv[k].d);
      chk("rx_valid", {7'b0, rx_valid}, {7'b0, rv[k].valid});
      chk("rx_overrun", {7'b0, rx_overrun}, {7'b0, rv[k].ovr});
      chk("rx_frame_err", {7'b0, rx_frame_err}, {7'b0, rv[k].ferr});
      chk("rx_data_head", rx_data, q.size() != 0 ? q[0] : 8'h00);
      for (int p = 0; p < rv[k].pops; p++) pop_chk();
      if (rv[k].clr) begin
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovr_clr", {7'b0, rx_overrun}, 8'h00);
        chk("ferr_clr", {7'b0, rx_frame_err}, 8'h00);
      end
      chk("rx_valid_post", {7'b0, rx_valid}, {7'b0, q.size() != 0});
      chk("rx_data_post", rx_data, q.size() != 0 ? q[0] : 8'h00);
    end
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(40);
    chk("glitch_valid", {7'b0, rx_valid}, 8'h00);
    chk("glitch_ferr", {7'b0, rx_frame_err}, 8'h00);
    send_frame(8'h3C, 1'b1);
    q.push_back(8'h3C);
    pop_chk();
    chk("after_glitch_empty", {7'b0, rx_valid}, 8'h00);
    tx_data = 8'h55;
    tx_we = 1'b1;
    uart_rxd = 1'b0;
    tick(1);
    tx_we = 1'b0;
    tick(15);
    uart_rxd = 1'b1;
    tick(24);
    chk("pre_rst_busy", {7'b0, tx_busy}, 8'h01);
    rst = 1'b1;
    #1;
    chk("async_rst_txd", {7'b0, uart_txd}, 8'h01);
    chk("async_rst_busy", {7'b0, tx_busy}, 8'h00);
    chk("async_rst_valid", {7'b0, rx_valid}, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(200);
    chk("post_rst_valid", {7'b0, rx_valid}, 8'h00);
    chk("post_rst_data", rx_data, 8'h00);
    chk("post_rst_ferr", {7'b0, rx_frame_err}, 8'h00);
    tx_chk(8'h42, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
UART controller that sits directly beside the pipelined data path's memory-mapped I/O decode, at 0x1000_0000 and 0x1000_0004.
- Consumes the TX write strobe and byte from the data path.
- Supplies the RX byte, RX-valid and TX-busy status back to it.
- Contains a TX serializer, an RX deserializer with mid-bit sampling, and a small first-word-fall-through RX FIFO.
- Drives and receives the board's serial pins.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 115200, line rate; DIV = CLK_FREQ/BAUD, integer-truncated, must be >= 4.
RX_DEPTH, 4, RX FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
tx_data  in  8  byte to transmit.
tx_we  in  1  one-cycle write strobe.
tx_busy  out  1  transmitter occupied.
rx_re  in  1  pop request (combinational load acknowledge from data path).
rx_data  out  8  FIFO head; 0x00 when empty.
rx_valid  out  1  FIFO non-empty.
rx_overrun  out  1  sticky: a byte was dropped because the FIFO was full.
rx_frame_err  out  1  sticky: a stop bit was sampled low.
err_clr  in  1  clears both sticky flags.
uart_rxd  in  1  serial input, asynchronous.
uart_txd  out  1  serial output, idle high.

Behaviour:
Reset and clocking
- One clock domain; reset is asynchronous and active-high.
- Reset values: uart_txd=1, tx_busy=0, rx_valid=0, rx_data=0x00, rx_overrun=0, rx_frame_err=0.
- Reset clears the FIFO and both FSMs. Reset mid-frame aborts the frame: the line goes high immediately and the partial byte is discarded.

TX FSM (TX_IDLE, TX_START, TX_DATA, TX_STOP)
- Baud counter counts 0..DIV-1.
- tx_we in TX_IDLE latches tx_data; next cycle: TX_START, uart_txd=0, tx_busy=1.
- Each bit lasts exactly DIV cycles. Frame order: start bit, then data LSB first over 8 bits, then one stop bit (uart_txd=1).
- tx_busy returns to 0 on the cycle after the stop bit's DIV cycles complete. Total busy time = 10*DIV cycles.
- tx_we while tx_busy=1 is ignored; the byte is lost and there is no error flag. Firmware polls bit1 of 0x1000_0004.

RX path
- uart_rxd passes through a 2-flop synchronizer (idle value 1 after reset).
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
- RX_IDLE: a synchronized falling edge goes to RX_START.
- RX_START: wait DIV/2 cycles, then resample. Low → RX_DATA; high → glitch, back to RX_IDLE with nothing recorded.
- RX_DATA: sample every DIV cycles, 8 bits, LSB first.
- RX_STOP: sample after DIV cycles.
  - Stop=1 → push the byte.
  - Stop=0 → discard the byte and set rx_frame_err.
  - In both cases return to RX_IDLE; a new start edge is accepted immediately.

RX FIFO
- First-word fall-through: rx_data is combinational from the head entry; rx_valid = count != 0.
- Pop: rx_re=1 and rx_valid=1 advances the head at the clock edge. rx_re while empty is a no-op.
- Push when full: the byte is dropped, rx_overrun is set, and contents are unchanged.
- Simultaneous push and pop when full: both proceed, count is unchanged, no overrun.
- Simultaneous push and pop when empty: the push wins and the pop is ignored, so the byte remains.
- Pointers are log2(RX_DEPTH) bits and wrap naturally; count is log2(RX_DEPTH)+1 bits.
- rx_re must be a single-cycle pulse per load. A multi-cycle assertion pops multiple entries, and this is intended.

Sticky flags
- err_clr clears both flags.
- A set event in the same cycle as err_clr wins: the flag ends at 1.

Decomposition:
- Shared package uart_pkg: TX/RX state encodings (2-bit localparams), frame bit count 8, and the MMIO addresses 0x1000_0000 and 0x1000_0004 for the data-path decode.
- Natural sub-module: uart_rx_fifo, a parameterized FWFT sync FIFO with push/pop/full/empty/count, instantiated once.
- TX and RX FSMs stay in the top.

Test Plan (CLK_FREQ=1600, BAUD=100, so DIV=16; RX_DEPTH=4):
1. Reset held 3 cycles, then released → uart_txd=1, tx_busy=0, rx_valid=0, rx_data=0x00, both flags 0.
2. tx_we with tx_data=0xA5 → after 1 cycle, uart_txd=0 for 16 cycles. Then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16. tx_busy is high for exactly 160 cycles. A second tx_we=0x3C at cycle 50 leaves the waveform unchanged.
3. Drive a 0x5A frame on uart_rxd (16 cycles/bit) → rx_valid rises after the stop-bit sample with rx_data=0x5A. A one-cycle rx_re → rx_valid=0 next cycle.
4. Send 5 frames 0x01..0x05 without popping → FIFO holds 0x01..0x04 and rx_overrun=1. Four pops return 0x01, 0x02, 0x03, 0x04. err_clr → rx_overrun=0.
5. Frame 0x77 with stop bit low → no push and rx_frame_err=1. Then a valid 0x78 frame → pushed. A 4-cycle low glitch on uart_rxd → nothing pushed.
6. Assert rst mid-TX (cycle 40) and mid-RX → uart_txd=1 immediately, tx_busy=0, FIFO empty. A fresh 0x42 transmit after release is clean.
